// File: rtl/rip_pkg.sv
// Purpose : shared types for the rip ALU and its sharers (decoded instruction, ALU request bundle).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: inst_t (one-hot decoded instruction), alu_req_t (full operand bundle), INST_NOP.
package rip_pkg;

  // One-hot decoded instruction; at most one field is set, all-zero is a NOP.
  typedef struct packed {
    logic op_lui;
    logic op_auipc;
    logic op_addi;
    logic op_slti;
    logic op_sltiu;
    logic op_xori;
    logic op_ori;
    logic op_andi;
    logic op_slli;
    logic op_srli;
    logic op_srai;
    logic op_add;
    logic op_sub;
    logic op_sll;
    logic op_slt;
    logic op_sltu;
    logic op_xor;
    logic op_srl;
    logic op_sra;
    logic op_or;
    logic op_and;
    logic op_csrrw;
    logic op_csrrs;
    logic op_csrrc;
    logic op_csrrwi;
    logic op_csrrsi;
    logic op_csrrci;
  } inst_t;

  typedef struct packed {
    inst_t       inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] csr;
    logic [31:0] imm;
    logic [4:0]  zimm;
  } alu_req_t;

  localparam inst_t INST_NOP = '0;

endpackage

// File: rtl/rip_alu.sv
// Purpose : single-issue integer/CSR ALU driven by a one-hot decoded instruction.
// Latency : 1 cycle, result registered (inputs at T, rslt valid in T+1).
// Backpressure: none; accepts a new operation every cycle, a NOP yields rslt = 0.
// Ports   : clk, rst_n (sync, active-low); inst + operands in; rslt out.
module rip_alu
  import rip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  inst_t       inst,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] pc,
  input  logic [31:0] csr,
  input  logic [31:0] imm,
  input  logic [4:0]  zimm,
  output logic [31:0] rslt
);

  logic [31:0] rslt_d, rslt_q;
  logic [31:0] zimm_ext;
  logic [4:0]  shamt_i, shamt_r;

  assign zimm_ext = {27'd0, zimm};
  assign shamt_i  = imm[4:0];
  assign shamt_r  = rs2[4:0];

  // CSR ops return the value written back to the CSR.
  always_comb begin
    rslt_d = '0;
    if      (inst.op_lui)    rslt_d = imm;
    else if (inst.op_auipc)  rslt_d = pc + imm;
    else if (inst.op_addi)   rslt_d = rs1 + imm;
    else if (inst.op_slti)   rslt_d = {31'd0, $signed(rs1) < $signed(imm)};
    else if (inst.op_sltiu)  rslt_d = {31'd0, rs1 < imm};
    else if (inst.op_xori)   rslt_d = rs1 ^ imm;
    else if (inst.op_ori)    rslt_d = rs1 | imm;
    else if (inst.op_andi)   rslt_d = rs1 & imm;
    else if (inst.op_slli)   rslt_d = rs1 << shamt_i;
    else if (inst.op_srli)   rslt_d = rs1 >> shamt_i;
    else if (inst.op_srai)   rslt_d = $unsigned($signed(rs1) >>> shamt_i);
    else if (inst.op_add)    rslt_d = rs1 + rs2;
    else if (inst.op_sub)    rslt_d = rs1 - rs2;
    else if (inst.op_sll)    rslt_d = rs1 << shamt_r;
    else if (inst.op_slt)    rslt_d = {31'd0, $signed(rs1) < $signed(rs2)};
    else if (inst.op_sltu)   rslt_d = {31'd0, rs1 < rs2};
    else if (inst.op_xor)    rslt_d = rs1 ^ rs2;
    else if (inst.op_srl)    rslt_d = rs1 >> shamt_r;
    else if (inst.op_sra)    rslt_d = $unsigned($signed(rs1) >>> shamt_r);
    else if (inst.op_or)     rslt_d = rs1 | rs2;
    else if (inst.op_and)    rslt_d = rs1 & rs2;
    else if (inst.op_csrrw)  rslt_d = rs1;
    else if (inst.op_csrrs)  rslt_d = csr | rs1;
    else if (inst.op_csrrc)  rslt_d = csr & ~rs1;
    else if (inst.op_csrrwi) rslt_d = zimm_ext;
    else if (inst.op_csrrsi) rslt_d = csr | zimm_ext;
    else if (inst.op_csrrci) rslt_d = csr & ~zimm_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rslt_q <= '0;
    else        rslt_q <= rslt_d;
  end

  assign rslt = rslt_q;

endmodule

// File: rtl/rip_rsp_fifo.sv
// Purpose : generic registered synchronous FIFO with occupancy count, full and empty flags.
// Latency : 1 cycle write-to-read (a push is visible at the head the following cycle).
// Backpressure: push is ignored when full unless a pop happens in the same cycle; pop ignored when empty.
// Ports   : clk_i, rst_i (sync, active-high); push_i/wdata_i; pop_i/rdata_o; count_o, full_o, empty_o.
module rip_rsp_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // When full, the write slot equals the head slot; the head is read
  // combinationally before the edge, so push+pop at full is safe.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    if (do_push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  // Stale storage is masked so the head reads as zero while empty.
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/rip_alu_arbiter.sv
// Purpose : shares one rip_alu among NREQ requesters via round-robin grant and returns tagged results.
// Latency : 2 cycles accept-to-response (ALU stage, then response FIFO); 1 request/cycle sustained.
// Backpressure: grants only while FIFO+inflight credits < RESP_DEPTH, so no result is dropped on rsp stall.
// Ports   : clk, rst (sync, active-high); req_* valid/ready bundles per requester; rsp_* valid/ready result.
module rip_alu_arbiter
  import rip_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int TAG_W      = 4,
  parameter int RESP_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  inst_t [NREQ-1:0]                 req_inst,
  input  logic [NREQ-1:0][31:0]            req_rs1,
  input  logic [NREQ-1:0][31:0]            req_rs2,
  input  logic [NREQ-1:0][31:0]            req_pc,
  input  logic [NREQ-1:0][31:0]            req_csr,
  input  logic [NREQ-1:0][31:0]            req_imm,
  input  logic [NREQ-1:0][4:0]             req_zimm,
  input  logic [NREQ-1:0][TAG_W-1:0]       req_tag,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [31:0]                      rsp_rslt,
  output logic [$clog2(NREQ)-1:0]          rsp_id,
  output logic [TAG_W-1:0]                 rsp_tag
);

  localparam int ID_W   = $clog2(NREQ);
  localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam int FIFO_W = 32 + ID_W + TAG_W;

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any, gnt_vld, credit_ok;
  logic [CNT_W:0]    credits_used;

  logic              inflight_vld_q;
  logic [ID_W-1:0]   inflight_id_q;
  logic [TAG_W-1:0]  inflight_tag_q;

  alu_req_t          alu_req;
  logic [31:0]       alu_rslt;

  logic              pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic [FIFO_W-1:0] fifo_rdata;

  // Round-robin search starting at ptr_q, wrapping modulo NREQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
  end

  assign pop = rsp_valid & rsp_ready;

  // A same-cycle pop frees its slot for this cycle's grant. pop implies
  // fifo_count >= 1, so the subtraction cannot underflow.
  assign credits_used = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_vld_q) - (CNT_W + 1)'(pop);
  assign credit_ok    = (credits_used < (CNT_W + 1)'(RESP_DEPTH));
  assign gnt_vld      = gnt_any & credit_ok & ~rst;

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Ungranted cycles feed an all-zero bundle (NOP), so the ALU emits 0.
  always_comb begin
    alu_req = '0;
    alu_req.inst = INST_NOP;
    if (gnt_vld) begin
      alu_req.inst = req_inst[gnt_idx];
      alu_req.rs1  = req_rs1[gnt_idx];
      alu_req.rs2  = req_rs2[gnt_idx];
      alu_req.pc   = req_pc[gnt_idx];
      alu_req.csr  = req_csr[gnt_idx];
      alu_req.imm  = req_imm[gnt_idx];
      alu_req.zimm = req_zimm[gnt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q          <= '0;
      inflight_vld_q <= 1'b0;
      inflight_id_q  <= '0;
      inflight_tag_q <= '0;
    end else begin
      ptr_q          <= ptr_d;
      inflight_vld_q <= gnt_vld;
      if (gnt_vld) begin
        inflight_id_q  <= gnt_idx;
        inflight_tag_q <= req_tag[gnt_idx];
      end
    end
  end

  rip_alu u_alu (
    .clk   (clk),
    .rst_n (~rst),
    .inst  (alu_req.inst),
    .rs1   (alu_req.rs1),
    .rs2   (alu_req.rs2),
    .pc    (alu_req.pc),
    .csr   (alu_req.csr),
    .imm   (alu_req.imm),
    .zimm  (alu_req.zimm),
    .rslt  (alu_rslt)
  );

  rip_rsp_fifo #(
    .W     (FIFO_W),
    .DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (inflight_vld_q),
    .wdata_i ({alu_rslt, inflight_id_q, inflight_tag_q}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rsp_valid = ~fifo_empty;
  assign {rsp_rslt, rsp_id, rsp_tag} = fifo_rdata;

endmodule

// File: tb/tb_rip_alu_arbiter.sv
// Purpose : directed self-checking bench for rip_alu_arbiter (NREQ=2, TAG_W=4, RESP_DEPTH=2).
// Latency : checks 2-cycle accept-to-response, grant order, credit stalls and reset flush.
// Backpressure: exercises rsp_ready held low, single-cycle pops and drain.
module tb_rip_alu_arbiter;
  import rip_pkg::*;

  typedef struct {
    logic        id;
    logic [3:0]  tag;
    logic [31:0] rslt;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid, req_ready;
  inst_t [1:0]          req_inst;
  logic [1:0][31:0]     req_rs1, req_rs2, req_pc, req_csr, req_imm;
  logic [1:0][4:0]      req_zimm;
  logic [1:0][3:0]      req_tag;
  logic                 rsp_valid, rsp_ready;
  logic [31:0]          rsp_rslt;
  logic [0:0]           rsp_id;
  logic [3:0]           rsp_tag;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [31:0] exp_rslt [2];
  int          cnt [2];
  bit          auto_reload;

  rip_alu_arbiter #(.NREQ(2), .TAG_W(4), .RESP_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_inst(req_inst),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pc(req_pc), .req_csr(req_csr),
    .req_imm(req_imm), .req_zimm(req_zimm), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rslt(rsp_rslt),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // The credit rule must never let a push reach a full FIFO without a pop.
  always @(negedge clk) begin
    if (!rst)
      chk("overflow", 32'(dut.inflight_vld_q & dut.fifo_full & ~dut.pop), 32'd0);
  end

  function automatic inst_t mk_addi();
    inst_t i;
    i = '0;
    i.op_addi = 1'b1;
    return i;
  endfunction

  // ADDI stream payload for requester r; result = rs1 + 0x10.
  task automatic load(input int r);
    req_inst[r] = mk_addi();
    req_rs1[r]  = 32'h1000 * (r + 1) + 32'(cnt[r]);
    req_rs2[r]  = '0;
    req_csr[r]  = '0;
    req_imm[r]  = 32'h10;
    req_tag[r]  = 4'(cnt[r] + r * 8);
    exp_rslt[r] = req_rs1[r] + 32'h10;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // One cycle: drive, check at negedge against hand-given ready/valid, record grant.
  task automatic run_cycle(input logic [1:0] vld, input logic rr,
                           input logic [1:0] erdy, input logic erv);
    exp_t e;
    int   r;
    req_valid = vld;
    rsp_ready = rr;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(erdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(erv));
    if (erv && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("rsp_rslt", rsp_rslt, e.rslt);
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      if (rr) void'(exp_q.pop_front());
    end
    r = erdy[1] ? 1 : 0;
    if (erdy != 2'b00) begin
      e.id = r[0];
      e.tag = req_tag[r];
      e.rslt = exp_rslt[r];
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    if (erdy != 2'b00 && auto_reload) begin
      cnt[r]++;
      load(r);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    req_inst = '0; req_rs1 = '0; req_rs2 = '0; req_pc = '0;
    req_csr = '0; req_imm = '0; req_zimm = '0; req_tag = '0;
    cnt[0] = 0; cnt[1] = 0;
    auto_reload = 1'b0;

    // Reset values, with requests pending during reset.
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rslt", rsp_rslt, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single ADDI: 5 + 7 = 12, id 0, tag 3, visible two cycles after accept.
    req_inst[0] = mk_addi();
    req_rs1[0] = 32'd5; req_imm[0] = 32'd7; req_tag[0] = 4'd3;
    exp_rslt[0] = 32'd12;
    run_cycle(2'b01, 1'b1, 2'b01, 1'b0);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b0);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b1);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b0);

    // Continuous contention: grants alternate 0,1,... one response per cycle.
    do_reset();
    auto_reload = 1'b1;
    load(0); load(1);
    run_cycle(2'b11, 1'b1, 2'b01, 1'b0);
    run_cycle(2'b11, 1'b1, 2'b10, 1'b0);
    for (int k = 0; k < 6; k++)
      run_cycle(2'b11, 1'b1, (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b1);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b1);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b0);
    chk("contention_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: two accepts, ten stalled cycles, then grant in the pop cycle.
    do_reset();
    load(0); load(1);
    run_cycle(2'b11, 1'b0, 2'b01, 1'b0);
    run_cycle(2'b11, 1'b0, 2'b10, 1'b0);
    for (int k = 0; k < 10; k++)
      run_cycle(2'b11, 1'b0, 2'b00, 1'b1);
    run_cycle(2'b11, 1'b1, 2'b01, 1'b1);
    run_cycle(2'b11, 1'b0, 2'b00, 1'b1);
    // FIFO full here: pop and grant together, then pop+push+grant.
    chk("fifo_full", 32'(dut.fifo_full), 32'd1);
    run_cycle(2'b11, 1'b1, 2'b10, 1'b1);
    run_cycle(2'b11, 1'b1, 2'b01, 1'b1);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b1);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b1);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b0);
    chk("backpressure_drained", 32'(exp_q.size()), 32'd0);

    // Operation values with rs1=3, rs2=5 on requester 1.
    auto_reload = 1'b0;
    req_rs1[1] = 32'd3; req_rs2[1] = 32'd5; req_csr[1] = 32'hF; req_imm[1] = '0;
    req_inst[1] = '0; req_inst[1].op_sub = 1'b1; req_tag[1] = 4'd1;
    exp_rslt[1] = 32'hFFFF_FFFE;
    run_cycle(2'b10, 1'b1, 2'b10, 1'b0);
    req_inst[1] = '0; req_inst[1].op_sltu = 1'b1; req_tag[1] = 4'd2;
    exp_rslt[1] = 32'd1;
    run_cycle(2'b10, 1'b1, 2'b10, 1'b0);
    req_inst[1] = '0; req_inst[1].op_csrrc = 1'b1; req_tag[1] = 4'd3;
    exp_rslt[1] = 32'hC;
    run_cycle(2'b10, 1'b1, 2'b10, 1'b1);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b1);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b1);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b0);
    chk("ops_drained", 32'(exp_q.size()), 32'd0);

    // Reset with one result queued and one inflight; nothing stale afterwards.
    do_reset();
    auto_reload = 1'b1;
    load(0); load(1);
    run_cycle(2'b01, 1'b0, 2'b01, 1'b0);
    run_cycle(2'b00, 1'b0, 2'b00, 1'b0);
    run_cycle(2'b01, 1'b0, 2'b01, 1'b1);
    chk("pre_rst_inflight", 32'(dut.inflight_vld_q), 32'd1);
    rst = 1'b1;
    run_cycle(2'b11, 1'b0, 2'b00, 1'b1);
    rst = 1'b0;
    exp_q.delete();
    chk("post_rst_ptr", 32'(dut.ptr_q), 32'd0);
    // ptr was 1 before reset; a grant to 0 with both valid shows it was cleared.
    run_cycle(2'b11, 1'b1, 2'b01, 1'b0);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b0);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b1);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b0);
    run_cycle(2'b00, 1'b1, 2'b00, 1'b0);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
